ahb_slave: RTL and testbench

AHB slave that terminates transfers from `ahb_master` onto a local word-addressed register memory. It decodes address-phase controls, inserts optional wait states, performs byte-lane writes and reads, and returns OKAY or the two-cycle ERROR response. It sits on the slave side of the AHB interconnect, behind the address decoder that drives `ahbs_HSEL`.

---
 rtl/ahb_slave_pkg.sv | 40 ++++
 rtl/ahb_slave_if.sv | 34 +++
 rtl/ahb_slave_mem.sv | 33 +++
 rtl/ahb_slave.sv | 127 ++++++++++++
 tb/tb_ahb_slave.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ahb_slave_pkg.sv
// ============================================================================
// Module : ahb_pkg
// Brief  : AHB encodings and the ahb_slave state type.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_t;

    // Little-endian lane mask; only legal (aligned, size <= word) accesses reach here.
    function automatic logic [3:0] byte_enables(input logic [1:0] lane, input logic [2:0] size);
        case (size)
            HSIZE_BYTE: return 4'b0001 << lane;
            HSIZE_HALF: return lane[1] ? 4'b1100 : 4'b0011;
            default:    return 4'b1111;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/ahb_slave_if.sv
// ============================================================================
// Module : ahb_slave_if
// Brief  : AHB slave-side bus bundle with master and slave modports.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface ahb_slave_if;
    logic        ahbs_HSEL;
    logic        ahbs_HREADYin;
    logic [31:0] ahbm_HADDR;
    logic [1:0]  ahbm_HTRANS;
    logic        ahbm_ahbs_HWRITE;
    logic [2:0]  ahbm_ahbs_HSIZE;
    logic [2:0]  ahbm_HBURST;
    logic [31:0] ahbm_ahbs_HWDATA;
    logic        ahbs_HREADY;
    logic [1:0]  ahbs_HRESP;
    logic [31:0] ahbs_ahbm_HRDATA;

    modport master (
        output ahbs_HSEL, ahbs_HREADYin, ahbm_HADDR, ahbm_HTRANS, ahbm_ahbs_HWRITE,
               ahbm_ahbs_HSIZE, ahbm_HBURST, ahbm_ahbs_HWDATA,
        input  ahbs_HREADY, ahbs_HRESP, ahbs_ahbm_HRDATA
    );

    modport slave (
        input  ahbs_HSEL, ahbs_HREADYin, ahbm_HADDR, ahbm_HTRANS, ahbm_ahbs_HWRITE,
               ahbm_ahbs_HSIZE, ahbm_HBURST, ahbm_ahbs_HWDATA,
        output ahbs_HREADY, ahbs_HRESP, ahbs_ahbm_HRDATA
    );
endinterface

`default_nettype wire

// File: rtl/ahb_slave_mem.sv
// ============================================================================
// Module : ahb_slave_mem
// Brief  : DEPTH x 32 flop array, per-byte write enable, asynchronous read.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ahb_slave_mem #(
    parameter int DEPTH = 256
) (
    input  wire logic                     clk,
    input  wire logic [3:0]               we,
    input  wire logic [$clog2(DEPTH)-1:0] addr,
    input  wire logic [31:0]              wdata,
    output logic      [31:0]              rdata
);

    // One byte-wide array per lane keeps each lane's storage single-driven.
    for (genvar b = 0; b < 4; b++) begin : g_lane
        logic [7:0] lane_mem [DEPTH];

        always_ff @(posedge clk) begin
            if (we[b]) begin
                lane_mem[addr] <= wdata[8*b +: 8];
            end
        end

        assign rdata[8*b +: 8] = lane_mem[addr];
    end

endmodule

`default_nettype wire

// File: rtl/ahb_slave.sv
// ============================================================================
// Module : ahb_slave
// Brief  : AHB slave onto a word-addressed register memory; OKAY/ERROR responses.
//          Wait states are built only when AHB_SLAVE_WAIT_EN is defined.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ahb_slave #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 1
) (
    input wire logic   HCLK,
    input wire logic   HRESETn,
    ahb_slave_if.slave bus
);
    import ahb_pkg::*;

    localparam int AW = $clog2(DEPTH);

    state_t        state;
    logic          hready_q;
    logic [1:0]    hresp_q;
    logic          dp_valid;
    logic [AW+1:0] addr_q;
    logic          write_q;
    logic [1:0]    size_q;
`ifdef AHB_SLAVE_WAIT_EN
    logic [3:0]    wait_cnt;
`endif

    logic        addr_phase;
    logic        req_err;
    logic        final_cycle;
    logic [3:0]  mem_we;
    logic [31:0] mem_rdata;

    assign addr_phase = bus.ahbs_HSEL & bus.ahbs_HREADYin & bus.ahbm_HTRANS[1];

    assign req_err = (|bus.ahbm_HADDR[31:AW+2])
                   | (bus.ahbm_ahbs_HSIZE > HSIZE_WORD)
                   | ((bus.ahbm_ahbs_HSIZE == HSIZE_HALF) & bus.ahbm_HADDR[0])
                   | ((bus.ahbm_ahbs_HSIZE == HSIZE_WORD) & (|bus.ahbm_HADDR[1:0]));

    // A good transfer's data phase ends in the first cycle it shows HREADY high.
    assign final_cycle = dp_valid & hready_q;
    assign mem_we      = (final_cycle & write_q) ? byte_enables(addr_q[1:0], {1'b0, size_q}) : 4'b0000;

    assign bus.ahbs_HREADY      = hready_q;
    assign bus.ahbs_HRESP       = hresp_q;
    assign bus.ahbs_ahbm_HRDATA = (final_cycle & ~write_q) ? mem_rdata : 32'h0;

    wire unused_bits = ^{bus.ahbm_HTRANS[0], bus.ahbm_HBURST};

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state    <= ST_IDLE;
            hready_q <= 1'b1;
            hresp_q  <= HRESP_OKAY;
            dp_valid <= 1'b0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            size_q   <= 2'd0;
`ifdef AHB_SLAVE_WAIT_EN
            wait_cnt <= 4'd0;
`endif
        end else begin
            case (state)
                // ERR2 drives HREADY high, so it samples the next address phase like IDLE.
                ST_IDLE, ST_ERR2: begin
                    state    <= ST_IDLE;
                    hready_q <= 1'b1;
                    hresp_q  <= HRESP_OKAY;
                    dp_valid <= 1'b0;
                    if (addr_phase) begin
                        addr_q  <= bus.ahbm_HADDR[AW+1:0];
                        write_q <= bus.ahbm_ahbs_HWRITE;
                        size_q  <= bus.ahbm_ahbs_HSIZE[1:0];
                        if (req_err) begin
                            state    <= ST_ERR1;
                            hready_q <= 1'b0;
                            hresp_q  <= HRESP_ERROR;
                        end else begin
                            dp_valid <= 1'b1;
`ifdef AHB_SLAVE_WAIT_EN
                            if (WAIT_CYCLES > 0) begin
                                state    <= ST_WAIT;
                                hready_q <= 1'b0;
                                wait_cnt <= 4'(WAIT_CYCLES - 1);
                            end
`endif
                        end
                    end
                end
                ST_WAIT: begin
`ifdef AHB_SLAVE_WAIT_EN
                    if (wait_cnt == 4'd0) begin
                        state    <= ST_IDLE;
                        hready_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
`else
                    state    <= ST_IDLE;
                    hready_q <= 1'b1;
`endif
                end
                ST_ERR1: begin
                    state    <= ST_ERR2;
                    hready_q <= 1'b1;
                    hresp_q  <= HRESP_ERROR;
                end
            endcase
        end
    end

    ahb_slave_mem #(.DEPTH(DEPTH)) u_mem (
        .clk   (HCLK),
        .we    (mem_we),
        .addr  (addr_q[AW+1:2]),
        .wdata (bus.ahbm_ahbs_HWDATA),
        .rdata (mem_rdata)
    );

endmodule

`default_nettype wire

// File: tb/tb_ahb_slave.sv
// ============================================================================
// Module : tb_ahb_slave
// Brief  : Self-checking bench for ahb_slave (directed table, reset cases, random).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_ahb_slave;
    import ahb_pkg::*;

    localparam int DEPTH       = 256;
    localparam int WAIT_CYCLES = 2;
`ifdef AHB_SLAVE_WAIT_EN
    localparam int EXP_WAITS = WAIT_CYCLES;
`else
    localparam int EXP_WAITS = 0;
`endif

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } xfer_t;

    typedef struct {
        logic        rdy;
        logic [1:0]  resp;
        logic [31:0] rdata;
        int          tag;
    } rsp_t;

    typedef struct {
        xfer_t       x;
        bit          exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    logic HCLK = 1'b0;
    logic HRESETn;
    always #5 HCLK = ~HCLK;

    ahb_slave_if bus();

    ahb_slave #(.DEPTH(DEPTH), .WAIT_CYCLES(WAIT_CYCLES)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    int          vectors     = 0;
    int          miscompares = 0;
    xfer_t       pend[$];
    rsp_t        expq[$];
    vec_t        tbl[$];
    logic [31:0] model [DEPTH];
    logic [31:0] obs_rdata [512];
    bit          obs_err   [512];
    xfer_t       idle_x;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic xfer_t mk(input logic sel, input logic [1:0] trans, input logic wr,
                                 input logic [2:0] size, input logic [31:0] addr, input logic [31:0] wdata);
        xfer_t x;
        x.sel = sel; x.trans = trans; x.wr = wr; x.size = size; x.addr = addr; x.wdata = wdata;
        return x;
    endfunction

    task automatic push_rsp(input logic rdy, input logic [1:0] resp, input logic [31:0] rdata, input int tag);
        rsp_t r;
        r.rdy = rdy; r.resp = resp; r.rdata = rdata; r.tag = tag;
        expq.push_back(r);
    endtask

    // Reference: per-transfer response list derived from the bus rules, memory as a word array.
    task automatic push_expect(input xfer_t x, input int tag);
        int word;
        int lane;
        if (!(x.sel && x.trans[1])) begin
            push_rsp(1'b1, 2'b00, 32'h0, tag);
            return;
        end
        if (x.addr >= 32'(4*DEPTH) || x.size > 3'd2 ||
            (x.size == 3'd1 && x.addr[0]) || (x.size == 3'd2 && x.addr[1:0] != 2'b00)) begin
            push_rsp(1'b0, 2'b01, 32'h0, tag);
            push_rsp(1'b1, 2'b01, 32'h0, tag);
            return;
        end
        repeat (EXP_WAITS) push_rsp(1'b0, 2'b00, 32'h0, tag);
        word = int'(x.addr >> 2);
        if (x.wr) begin
            for (int b = 0; b < (1 << x.size); b++) begin
                lane = int'(x.addr[1:0]) + b;
                model[word][8*lane +: 8] = x.wdata[8*lane +: 8];
            end
            push_rsp(1'b1, 2'b00, 32'h0, tag);
        end else begin
            push_rsp(1'b1, 2'b00, model[word], tag);
        end
    endtask

    task automatic drive_addr(input xfer_t x, input logic rdy);
        bus.ahbs_HSEL        = x.sel;
        bus.ahbs_HREADYin    = rdy;
        bus.ahbm_HTRANS      = x.trans;
        bus.ahbm_ahbs_HWRITE = x.wr;
        bus.ahbm_ahbs_HSIZE  = x.size;
        bus.ahbm_HADDR       = x.addr;
        bus.ahbm_HBURST      = 3'($urandom_range(0, 7));
    endtask

    // Pipelined driver: call just after a negedge with the slave ready.
    task automatic run_seq();
        int    idx = 0;
        int    n = pend.size();
        int    cycles = 0;
        bit    mrdy = 1'b1;
        xfer_t dph = idle_x;
        rsp_t  r;
        if (n == 0) return;
        for (int i = 0; i < 512; i++) begin
            obs_rdata[i] = 32'h0;
            obs_err[i]   = 1'b0;
        end
        drive_addr(pend[0], 1'b1);
        forever begin
            @(posedge HCLK);
            if (mrdy) begin
                if (idx < n) begin
                    push_expect(pend[idx], idx);
                    dph = pend[idx];
                    idx++;
                end else begin
                    dph = idle_x;
                end
            end
            #1 bus.ahbm_ahbs_HWDATA = dph.wdata;
            @(negedge HCLK);
            cycles++;
            if (expq.size() > 0) begin
                r = expq.pop_front();
                check("hready", {31'b0, bus.ahbs_HREADY}, {31'b0, r.rdy});
                check("hresp",  {30'b0, bus.ahbs_HRESP},  {30'b0, r.resp});
                check("hrdata", bus.ahbs_ahbm_HRDATA, r.rdata);
                if (bus.ahbs_HRESP == HRESP_ERROR) obs_err[r.tag] = 1'b1;
                if (r.rdy) obs_rdata[r.tag] = bus.ahbs_ahbm_HRDATA;
                mrdy = r.rdy;
            end else begin
                mrdy = 1'b1;
            end
            if (idx < n) drive_addr(pend[idx], mrdy);
            else         drive_addr(idle_x, mrdy);
            if (idx >= n && expq.size() == 0) break;
            if (cycles > 20*n + 50) begin
                vectors++;
                miscompares++;
                $display("FAIL seq_timeout: got %0d cycles, expected at most %0d", cycles, 20*n + 50);
                break;
            end
        end
        pend.delete();
        expq.delete();
    endtask

    // Assert reset in the first data-phase cycle of x; the transfer must be dropped.
    task automatic reset_mid(input xfer_t x, input string nm);
        drive_addr(x, 1'b1);
        @(posedge HCLK);
        #1 bus.ahbm_ahbs_HWDATA = x.wdata;
        #2 HRESETn = 1'b0;
        #1;
        check({nm, "_hready"}, {31'b0, bus.ahbs_HREADY}, 32'h1);
        check({nm, "_hresp"},  {30'b0, bus.ahbs_HRESP},  32'h0);
        check({nm, "_hrdata"}, bus.ahbs_ahbm_HRDATA,     32'h0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        drive_addr(idle_x, 1'b1);
    endtask

    function automatic xfer_t rand_x();
        xfer_t x;
        int    k;
        int    word;
        x.sel = ($urandom_range(0, 7) != 0);
        k = $urandom_range(0, 9);
        x.trans = (k < 1) ? HTRANS_IDLE : (k < 2) ? HTRANS_BUSY : (k < 6) ? HTRANS_NONSEQ : HTRANS_SEQ;
        x.wr = 1'($urandom_range(0, 1));
        x.size = ($urandom_range(0, 19) == 0) ? 3'(3 + $urandom_range(0, 4)) : 3'($urandom_range(0, 2));
        word = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 15) : $urandom_range(0, DEPTH-1);
        x.addr = 32'(word * 4);
        if (x.size == 3'd0)      x.addr[1:0] = 2'($urandom_range(0, 3));
        else if (x.size == 3'd1) x.addr[1:0] = {1'($urandom_range(0, 1)), 1'b0};
        if ($urandom_range(0, 9) == 0)  x.addr[1:0] = 2'($urandom_range(0, 3));
        if ($urandom_range(0, 19) == 0) x.addr = $urandom | 32'(4*DEPTH);
        x.wdata = $urandom;
        return x;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        idle_x = mk(1'b0, HTRANS_IDLE, 1'b0, 3'd0, 32'h0, 32'h0);
        HRESETn = 1'b0;
        drive_addr(idle_x, 1'b1);
        bus.ahbm_ahbs_HWDATA = 32'h0;
        repeat (2) @(negedge HCLK);
        check("reset_hready", {31'b0, bus.ahbs_HREADY}, 32'h1);
        check("reset_hresp",  {30'b0, bus.ahbs_HRESP},  32'h0);
        check("reset_hrdata", bus.ahbs_ahbm_HRDATA,     32'h0);
        HRESETn = 1'b1;
        @(negedge HCLK);

        for (int w = 0; w < DEPTH; w++)
            pend.push_back(mk(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_WORD, 32'(w*4), 32'h0));
        run_seq();

        tbl.push_back('{mk(1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h10,  32'hDEADBEEF), 1'b0, 32'h0});
        tbl.push_back('{mk(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h10,  32'h0),        1'b0, 32'hDEADBEEF});
        tbl.push_back('{mk(1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h10,  32'h0),        1'b0, 32'h0});
        tbl.push_back('{mk(1, HTRANS_NONSEQ, 1, HSIZE_BYTE, 32'h13,  32'hAA000000), 1'b0, 32'h0});
        tbl.push_back('{mk(1, HTRANS_NONSEQ, 1, HSIZE_HALF, 32'h10,  32'h00001234), 1'b0, 32'h0});
        tbl.push_back('{mk(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h10,  32'h0),        1'b0, 32'hAA001234});
        tbl.push_back('{mk(1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h402, 32'hFFFFFFFF), 1'b1, 32'h0});
        tbl.push_back('{mk(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h400, 32'h0),        1'b1, 32'h0});
        tbl.push_back('{mk(1, HTRANS_NONSEQ, 1, 3'd3,       32'h10,  32'hFFFFFFFF), 1'b1, 32'h0});
        tbl.push_back('{mk(1, HTRANS_NONSEQ, 1, HSIZE_HALF, 32'h11,  32'hFFFFFFFF), 1'b1, 32'h0});
        tbl.push_back('{mk(1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h12,  32'hFFFFFFFF), 1'b1, 32'h0});
        tbl.push_back('{mk(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h10,  32'h0),        1'b0, 32'hAA001234});
        tbl.push_back('{mk(1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h4,   32'h11112222), 1'b0, 32'h0});
        tbl.push_back('{mk(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h0,   32'h0),        1'b0, 32'h0});
        tbl.push_back('{mk(1, HTRANS_BUSY,   1, HSIZE_WORD, 32'h4,   32'hBADBAD00), 1'b0, 32'h0});
        tbl.push_back('{mk(1, HTRANS_SEQ,    0, HSIZE_WORD, 32'h4,   32'h0),        1'b0, 32'h11112222});
        tbl.push_back('{mk(1, HTRANS_IDLE,   1, HSIZE_WORD, 32'h4,   32'hDEAD0000), 1'b0, 32'h0});
        tbl.push_back('{mk(0, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h4,   32'h55555555), 1'b0, 32'h0});
        tbl.push_back('{mk(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h0,   32'h0),        1'b0, 32'h0});
        tbl.push_back('{mk(1, HTRANS_SEQ,    0, HSIZE_WORD, 32'h4,   32'h0),        1'b0, 32'h11112222});
        tbl.push_back('{mk(1, HTRANS_SEQ,    0, HSIZE_WORD, 32'h8,   32'h0),        1'b0, 32'h0});
        tbl.push_back('{mk(1, HTRANS_SEQ,    0, HSIZE_WORD, 32'hC,   32'h0),        1'b0, 32'h0});
        tbl.push_back('{mk(1, HTRANS_NONSEQ, 0, HSIZE_BYTE, 32'h13,  32'h0),        1'b0, 32'hAA001234});
        for (int i = 0; i < tbl.size(); i++) pend.push_back(tbl[i].x);
        run_seq();
        for (int i = 0; i < tbl.size(); i++) begin
            check($sformatf("vec%0d_rdata", i), obs_rdata[i], tbl[i].exp_rdata);
            check($sformatf("vec%0d_err", i), {31'b0, obs_err[i]}, {31'b0, tbl[i].exp_err});
        end

        reset_mid(mk(1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h3FF, 32'h12345678), "rst_err1");
        reset_mid(mk(1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h20,  32'hCAFEF00D), "rst_write");
        reset_mid(mk(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h10,  32'h0),        "rst_read");
        pend.push_back(mk(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h20, 32'h0));
        pend.push_back(mk(1, HTRANS_NONSEQ, 1, HSIZE_WORD, 32'h20, 32'h0BADF00D));
        pend.push_back(mk(1, HTRANS_NONSEQ, 0, HSIZE_WORD, 32'h20, 32'h0));
        run_seq();
        check("post_reset_old", obs_rdata[0], 32'h0);
        check("post_reset_new", obs_rdata[2], 32'h0BADF00D);

        for (int i = 0; i < 300; i++) pend.push_back(rand_x());
        run_seq();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
